// File: rtl/instr_decode_stage.sv
// RV32I decode stage: one-entry buffer, field/immediate decode; RAW scoreboard only with ID_SCOREBOARD_EN.
// Latency 1 (registered on accept); accept+issue same cycle; stalls on hazard, holds while READY_IN_ID=0.
module instr_decode_stage #(
  parameter int          NREG      = 32,
  parameter int          AW        = 5,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic [31:0]   INSTR_ID,
  input  logic [31:0]   PC_ID,
  input  logic          VALID_IN_ID,
  output logic          READY_OUT_ID,
  input  logic          FLUSH_ID,
  input  logic          WB_WE_ID,
  input  logic [AW-1:0] WB_RW_ID,
  output logic          VALID_OUT_ID,
  input  logic          READY_IN_ID,
  output logic [AW-1:0] RA_ID,
  output logic [AW-1:0] RB_ID,
  output logic [AW-1:0] RW_ID,
  output logic          WE_ID,
  output logic [31:0]   IMM_ID,
  output logic [2:0]    FMT_ID,
  output logic          ILLEGAL_ID,
  output logic [31:0]   PC_OUT_ID,
  output logic [31:0]   INSTR_OUT_ID
);
  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [2:0] FMT_X = 3'd7;

  typedef struct packed {
    logic [2:0]    fmt;
    logic          ill;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [AW-1:0] rw;
    logic          we;
    logic [31:0]   imm;
  } dec_t;

  dec_t        w_dec;
  dec_t        r_dec;
  logic        r_full;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        w_hazard;
  logic        w_issue;
  logic        w_accept;

  always_comb begin
    w_dec = '0;
    case (INSTR_ID[6:0])
      7'b0110011:                         w_dec.fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111: w_dec.fmt = FMT_I;
      7'b0100011:                         w_dec.fmt = FMT_S;
      7'b1100011:                         w_dec.fmt = FMT_B;
      7'b0110111, 7'b0010111:             w_dec.fmt = FMT_U;
      7'b1101111:                         w_dec.fmt = FMT_J;
      default:                            w_dec.fmt = FMT_X;
    endcase
    w_dec.ill = (w_dec.fmt == FMT_X);
    // Unused register fields stay 0 so they never address the RF or trip the hazard check.
    case (w_dec.fmt)
      FMT_R: begin
        w_dec.ra = INSTR_ID[19:15];
        w_dec.rb = INSTR_ID[24:20];
        w_dec.rw = INSTR_ID[11:7];
      end
      FMT_I: begin
        w_dec.ra  = INSTR_ID[19:15];
        w_dec.rw  = INSTR_ID[11:7];
        w_dec.imm = {{20{INSTR_ID[31]}}, INSTR_ID[31:20]};
      end
      FMT_S: begin
        w_dec.ra  = INSTR_ID[19:15];
        w_dec.rb  = INSTR_ID[24:20];
        w_dec.imm = {{20{INSTR_ID[31]}}, INSTR_ID[31:25], INSTR_ID[11:7]};
      end
      FMT_B: begin
        w_dec.ra  = INSTR_ID[19:15];
        w_dec.rb  = INSTR_ID[24:20];
        w_dec.imm = {{19{INSTR_ID[31]}}, INSTR_ID[31], INSTR_ID[7], INSTR_ID[30:25], INSTR_ID[11:8], 1'b0};
      end
      FMT_U: begin
        w_dec.rw  = INSTR_ID[11:7];
        w_dec.imm = {INSTR_ID[31:12], 12'b0};
      end
      FMT_J: begin
        w_dec.rw  = INSTR_ID[11:7];
        w_dec.imm = {{11{INSTR_ID[31]}}, INSTR_ID[31], INSTR_ID[19:12], INSTR_ID[20], INSTR_ID[30:21], 1'b0};
      end
      default: ;
    endcase
    w_dec.we = (w_dec.rw != '0);
  end

  assign VALID_OUT_ID = r_full & ~w_hazard & ~RES & ~FLUSH_ID;
  assign w_issue      = VALID_OUT_ID & READY_IN_ID;
  assign READY_OUT_ID = ~RES & ~FLUSH_ID & (~r_full | w_issue);
  assign w_accept     = VALID_IN_ID & READY_OUT_ID;

  always_ff @(posedge CLK) begin
    if (RES || FLUSH_ID) begin
      r_full  <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_dec   <= '0;
    end else if (w_accept) begin
      r_full  <= 1'b1;
      r_instr <= INSTR_ID;
      r_pc    <= PC_ID;
      r_dec   <= w_dec;
    end else if (w_issue) begin
      r_full  <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_dec   <= '0;
    end
  end

`ifdef ID_SCOREBOARD_EN
  logic [NREG-1:0] r_sb;

  // Set is applied after clear so a same-cycle set/clear of one register leaves it pending.
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_sb <= '0;
    end else begin
      if (WB_WE_ID && (WB_RW_ID != '0)) r_sb[WB_RW_ID] <= 1'b0;
      if (w_issue && r_dec.we)          r_sb[r_dec.rw] <= 1'b1;
    end
  end

  assign w_hazard = r_full & (((r_dec.ra != '0) & r_sb[r_dec.ra]) | ((r_dec.rb != '0) & r_sb[r_dec.rb]));
`else
  wire w_unused = &{1'b0, WB_WE_ID, WB_RW_ID, NREG[0]};
  assign w_hazard = 1'b0;
`endif

  assign RA_ID        = r_dec.ra;
  assign RB_ID        = r_dec.rb;
  assign RW_ID        = r_dec.rw;
  assign WE_ID        = r_dec.we;
  assign IMM_ID       = r_dec.imm;
  assign FMT_ID       = r_dec.fmt;
  assign ILLEGAL_ID   = r_dec.ill;
  assign PC_OUT_ID    = r_pc;
  assign INSTR_OUT_ID = r_instr;
endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: cycle-level reference model feeds an expectation queue; a monitor checks every issue.
`timescale 1ns/1ps
module tb_instr_decode_stage;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic [31:0] INSTR_ID = '0;
  logic [31:0] PC_ID = '0;
  logic        VALID_IN_ID = 1'b0;
  logic        READY_OUT_ID;
  logic        FLUSH_ID = 1'b0;
  logic        WB_WE_ID = 1'b0;
  logic [4:0]  WB_RW_ID = '0;
  logic        VALID_OUT_ID;
  logic        READY_IN_ID = 1'b0;
  logic [4:0]  RA_ID, RB_ID, RW_ID;
  logic        WE_ID;
  logic [31:0] IMM_ID;
  logic [2:0]  FMT_ID;
  logic        ILLEGAL_ID;
  logic [31:0] PC_OUT_ID;
  logic [31:0] INSTR_OUT_ID;

  instr_decode_stage dut (
    .CLK(CLK), .RES(RES), .INSTR_ID(INSTR_ID), .PC_ID(PC_ID), .VALID_IN_ID(VALID_IN_ID),
    .READY_OUT_ID(READY_OUT_ID), .FLUSH_ID(FLUSH_ID), .WB_WE_ID(WB_WE_ID), .WB_RW_ID(WB_RW_ID),
    .VALID_OUT_ID(VALID_OUT_ID), .READY_IN_ID(READY_IN_ID), .RA_ID(RA_ID), .RB_ID(RB_ID),
    .RW_ID(RW_ID), .WE_ID(WE_ID), .IMM_ID(IMM_ID), .FMT_ID(FMT_ID), .ILLEGAL_ID(ILLEGAL_ID),
    .PC_OUT_ID(PC_OUT_ID), .INSTR_OUT_ID(INSTR_OUT_ID)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0]  fmt;
    logic        ill;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rw;
    logic        we;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic        m_full = 1'b0;
  logic [31:0] m_instr = NOP;
  logic [31:0] m_pc = '0;
  logic [31:0] m_pend = '0;
  logic [31:0] pc_ctr = 32'h0000_1000;
  logic [6:0]  OPS [0:8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                             7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  // Reference decode written from the instruction-format rules.
  function automatic exp_t ref_dec(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    e = '0;
    e.pc = pc;
    e.instr = i;
    case (i[6:0])
      7'b0110011:                         e.fmt = 3'd0;
      7'b0010011, 7'b0000011, 7'b1100111: e.fmt = 3'd1;
      7'b0100011:                         e.fmt = 3'd2;
      7'b1100011:                         e.fmt = 3'd3;
      7'b0110111, 7'b0010111:             e.fmt = 3'd4;
      7'b1101111:                         e.fmt = 3'd5;
      default:                            e.fmt = 3'd7;
    endcase
    e.ill = (e.fmt == 3'd7);
    if (e.fmt inside {3'd0, 3'd1, 3'd2, 3'd3}) e.ra = i[19:15];
    if (e.fmt inside {3'd0, 3'd2, 3'd3})       e.rb = i[24:20];
    if ((e.fmt inside {3'd0, 3'd1, 3'd4, 3'd5}) && i[11:7] != 0) begin
      e.rw = i[11:7];
      e.we = 1'b1;
    end
    case (e.fmt)
      3'd1:    e.imm = 32'($signed(i[31:20]));
      3'd2:    e.imm = 32'($signed({i[31:25], i[11:7]}));
      3'd3:    e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      3'd4:    e.imm = {i[31:12], 12'h000};
      3'd5:    e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      default: e.imm = 32'h0;
    endcase
    return e;
  endfunction

  function automatic bit m_hazard(input exp_t e);
`ifdef ID_SCOREBOARD_EN
    return m_full && ((e.ra != 0 && m_pend[e.ra]) || (e.rb != 0 && m_pend[e.rb]));
`else
    return (e.fmt == 3'd6) && 1'b0;
`endif
  endfunction

  // One clock cycle: drive inputs just after an edge, check handshake mid-cycle, advance the model on the edge.
  task automatic step(input logic res, input logic flush, input logic v, input logic [31:0] ins,
                      input logic rdy, input logic wbwe, input logic [4:0] wbrw);
    exp_t cur;
    bit   ev, er, iss, acc;
    RES = res; FLUSH_ID = flush; VALID_IN_ID = v; INSTR_ID = ins; PC_ID = pc_ctr;
    READY_IN_ID = rdy; WB_WE_ID = wbwe; WB_RW_ID = wbrw;
    cur = ref_dec(m_instr, m_pc);
    ev  = !res && !flush && m_full && !m_hazard(cur);
    iss = ev && rdy;
    er  = !res && !flush && (!m_full || iss);
    acc = v && er;
    if (iss) q.push_back(cur);
    @(negedge CLK);
    chk("valid_out", {31'b0, VALID_OUT_ID}, {31'b0, ev});
    chk("ready_out", {31'b0, READY_OUT_ID}, {31'b0, er});
    chk("instr_out", INSTR_OUT_ID, m_full ? m_instr : NOP);
    if (m_full) chk("pc_out", PC_OUT_ID, m_pc);
    @(posedge CLK);
    #1;
    if (res) begin
      m_full = 1'b0;
      m_pend = '0;
    end else begin
      if (wbwe && wbrw != 0) m_pend[wbrw] = 1'b0;
      if (flush) m_full = 1'b0;
      else begin
        if (iss && cur.we) m_pend[cur.rw] = 1'b1;
        if (acc) begin
          m_full = 1'b1;
          m_instr = ins;
          m_pc = pc_ctr;
        end else if (iss) m_full = 1'b0;
      end
    end
    pc_ctr += 4;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (VALID_OUT_ID === 1'b1 && READY_IN_ID === 1'b1) begin
      if (q.size() == 0) chk("unexpected_issue", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("mon_instr", INSTR_OUT_ID, e.instr);
        chk("mon_pc", PC_OUT_ID, e.pc);
        chk("mon_fmt", {29'b0, FMT_ID}, {29'b0, e.fmt});
        chk("mon_ill", {31'b0, ILLEGAL_ID}, {31'b0, e.ill});
        chk("mon_ra", {27'b0, RA_ID}, {27'b0, e.ra});
        chk("mon_rb", {27'b0, RB_ID}, {27'b0, e.rb});
        chk("mon_rw", {27'b0, RW_ID}, {27'b0, e.rw});
        chk("mon_we", {31'b0, WE_ID}, {31'b0, e.we});
        chk("mon_imm", IMM_ID, e.imm);
      end
    end
  end

  initial begin
    logic [31:0] ins;
    logic [4:0]  wbrw;
    logic        wbwe;
    int          cand[$];
    @(posedge CLK);
    #1;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 32'h00500093, 1, 0, 0);
    chk("rst_valid", {31'b0, VALID_OUT_ID}, 0);
    chk("rst_ready", {31'b0, READY_OUT_ID}, 0);
    chk("rst_instr", INSTR_OUT_ID, NOP);
    chk("rst_pc", PC_OUT_ID, 0);
    chk("rst_imm", IMM_ID, 0);
    chk("rst_fields", {21'b0, FMT_ID, RA_ID, RW_ID, WE_ID}, 0);

    step(0, 0, 1, 32'h00500093, 0, 0, 0);            // addi x1,x0,5
    chk("addi_fmt", {29'b0, FMT_ID}, 1);
    chk("addi_ra", {27'b0, RA_ID}, 0);
    chk("addi_rw", {27'b0, RW_ID}, 1);
    chk("addi_we", {31'b0, WE_ID}, 1);
    chk("addi_imm", IMM_ID, 5);
    step(0, 0, 1, 32'hFE20AE23, 1, 0, 0);            // sw x2,-4(x1)
    chk("sw_fmt", {29'b0, FMT_ID}, 2);
    chk("sw_ra", {27'b0, RA_ID}, 1);
    chk("sw_rb", {27'b0, RB_ID}, 2);
    chk("sw_we_rw", {26'b0, WE_ID, RW_ID}, 0);
    chk("sw_imm", IMM_ID, 32'hFFFFFFFC);
    step(0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 1, 0, 0);

    step(0, 0, 1, 32'h00500093, 1, 0, 0);            // RAW: addi x1 then add x3,x1,x2
    step(0, 0, 1, 32'h002081B3, 1, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 1, 0, 0);

    step(0, 0, 1, 32'hFFFFFFFF, 0, 0, 0);            // illegal
    chk("ill_flag", {31'b0, ILLEGAL_ID}, 1);
    chk("ill_fmt", {29'b0, FMT_ID}, 7);
    chk("ill_we_imm", {31'b0, WE_ID} | IMM_ID, 0);
    chk("ill_ra_rb", {22'b0, RA_ID, RB_ID}, 0);
    step(0, 0, 0, 0, 1, 0, 0);

    step(0, 0, 1, 32'h00500093, 0, 0, 0);            // backpressure
    step(0, 0, 1, 32'h002081B3, 0, 0, 0);
    step(0, 0, 1, 32'h002081B3, 1, 0, 0);
    chk("bp_next_instr", INSTR_OUT_ID, 32'h002081B3);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 1, 32'h00500093, 1, 0, 0);            // flush keeps pending x1
    chk("flush_instr", INSTR_OUT_ID, NOP);
    step(0, 0, 1, 32'h002081B3, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);                       // reset clears pending x1
    step(0, 0, 1, 32'h002081B3, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);

    for (int c = 0; c < 3000; c++) begin
      ins = $urandom;
      if ($urandom_range(7) != 0) begin
        ins[6:0]   = OPS[$urandom_range(8)];
        ins[11:7]  = 5'($urandom_range(7));
        ins[19:15] = 5'($urandom_range(7));
        ins[24:20] = 5'($urandom_range(7));
      end
      cand.delete();
      for (int r = 1; r < 32; r++) if (m_pend[r]) cand.push_back(r);
      if (cand.size() != 0 && $urandom_range(1) == 1) begin
        wbwe = 1'b1;
        wbrw = 5'(cand[$urandom_range(cand.size() - 1)]);
      end else begin
        wbwe = ($urandom_range(3) == 0);
        wbrw = 5'($urandom_range(31));
      end
      step($urandom_range(127) == 0, $urandom_range(15) == 0, $urandom_range(3) != 0, ins,
           $urandom_range(3) != 0, wbwe, wbrw);
    end
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 1, 0, 0);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
